// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage. It borrows the shared
// ALU for one ADD (multiply) or SUB (divide) per iteration and writes results to HI/LO.
`ifndef CODE_ALU_EX_ADD
`define CODE_ALU_EX_ADD 6'b100000
`endif
`ifndef CODE_ALU_EX_SUB
`define CODE_ALU_EX_SUB 6'b100010
`endif

module alu_muldiv_sequencer #(
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       CTR_BUS_WIDTH = 6,
    parameter logic [CTR_BUS_WIDTH-1:0] ALU_CODE_ADD  = `CODE_ALU_EX_ADD,
    parameter logic [CTR_BUS_WIDTH-1:0] ALU_CODE_SUB  = `CODE_ALU_EX_SUB
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [1:0]               i_op,
    input  logic [DATA_WIDTH-1:0]    i_rs,
    input  logic [DATA_WIDTH-1:0]    i_rt,
    input  logic                     i_flush,
    input  logic [DATA_WIDTH-1:0]    i_alu_result,
    output logic                     o_alu_req,
    output logic [CTR_BUS_WIDTH-1:0] o_alu_ctr_code,
    output logic [DATA_WIDTH-1:0]    o_alu_data_a,
    output logic [DATA_WIDTH-1:0]    o_alu_data_b,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_div_by_zero,
    output logic [DATA_WIDTH-1:0]    o_hi,
    output logic [DATA_WIDTH-1:0]    o_lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_e;

    state_e          state_q;
    logic [1:0]      op_q;
    logic [W-1:0]    opa_q;
    logic [W-1:0]    opb_q;
    logic [W-1:0]    rs_q;
    logic [W-1:0]    acc_hi_q;
    logic [W-1:0]    acc_lo_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_res_q;
    logic            neg_rem_q;
    logic            dbz_pend_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic            done_q;
    logic            dbz_q;

    function automatic logic [W-1:0] negate(input logic [W-1:0] x);
        return ~x + {{(W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [W-1:0] abs_val(input logic [W-1:0] x, input logic sgn);
        return (sgn && x[W-1]) ? negate(x) : x;
    endfunction

    logic                     is_div;
    logic                     start_signed;
    logic [W-1:0]             shifted;
    logic                     msb_out;
    logic                     sub_ok;
    logic                     carry;
    logic [CTR_BUS_WIDTH-1:0] alu_code;
    logic [W-1:0]             alu_a;
    logic [W-1:0]             alu_b;
    logic [2*W-1:0]           prod_neg;
    logic [W-1:0]             fix_hi;
    logic [W-1:0]             fix_lo;

    assign is_div       = op_q[1];
    assign start_signed = i_op[0];
    assign shifted      = {acc_hi_q[W-2:0], acc_lo_q[W-1]};
    assign msb_out      = acc_hi_q[W-1];
    assign sub_ok       = msb_out | (shifted >= opb_q);
    assign carry        = (alu_a[W-1] & alu_b[W-1]) |
                          ((alu_a[W-1] | alu_b[W-1]) & ~i_alu_result[W-1]);
    assign prod_neg     = ~{acc_hi_q, acc_lo_q} + {{(2*W-1){1'b0}}, 1'b1};

    // ALU operands are only presented while the sequencer owns the ALU
    always_comb begin
        alu_code = '0;
        alu_a    = '0;
        alu_b    = '0;
        if (state_q == ITER) begin
            if (is_div) begin
                alu_code = ALU_CODE_SUB;
                alu_a    = shifted;
                alu_b    = opb_q;
            end else begin
                alu_code = ALU_CODE_ADD;
                alu_a    = acc_hi_q;
                alu_b    = acc_lo_q[0] ? opa_q : '0;
            end
        end
    end

    always_comb begin
        fix_hi = acc_hi_q;
        fix_lo = acc_lo_q;
        if (is_div) begin
            if (neg_res_q) fix_lo = negate(acc_lo_q);
            if (neg_rem_q) fix_hi = negate(acc_hi_q);
        end else if (neg_res_q) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            rs_q       <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            cnt_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (i_flush) begin
                state_q    <= IDLE;
                dbz_pend_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_start) begin
                            op_q       <= i_op;
                            rs_q       <= i_rs;
                            opa_q      <= abs_val(i_rs, start_signed);
                            opb_q      <= abs_val(i_rt, start_signed);
                            neg_res_q  <= start_signed & (i_rs[W-1] ^ i_rt[W-1]);
                            neg_rem_q  <= start_signed & i_op[1] & i_rs[W-1];
                            acc_hi_q   <= '0;
                            acc_lo_q   <= i_op[1] ? abs_val(i_rs, start_signed)
                                                  : abs_val(i_rt, start_signed);
                            cnt_q      <= '0;
                            dbz_pend_q <= 1'b0;
                            state_q    <= PREP;
                        end
                    end
                    PREP: begin
                        if (is_div && (opb_q == '0)) begin
                            hi_q       <= rs_q;
                            lo_q       <= '1;
                            dbz_pend_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q <= ITER;
                        end
                    end
                    ITER: begin
                        if (is_div) begin
                            acc_hi_q <= sub_ok ? i_alu_result : shifted;
                            acc_lo_q <= {acc_lo_q[W-2:0], sub_ok};
                        end else begin
                            {acc_hi_q, acc_lo_q} <= {carry, i_alu_result, acc_lo_q[W-1:1]};
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) state_q <= FIX;
                    end
                    FIX: begin
                        hi_q    <= fix_hi;
                        lo_q    <= fix_lo;
                        state_q <= DONE;
                    end
                    DONE: begin
                        // Completion is registered, so the pulse appears as the FSM returns to IDLE
                        done_q     <= 1'b1;
                        dbz_q      <= dbz_pend_q;
                        dbz_pend_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_alu_req      = (state_q == ITER);
    assign o_alu_ctr_code = alu_code;
    assign o_alu_data_a   = alu_a;
    assign o_alu_data_b   = alu_b;
    assign o_busy         = (state_q != IDLE);
    assign o_done         = done_q;
    assign o_div_by_zero  = dbz_q;
    assign o_hi           = hi_q;
    assign o_lo           = lo_q;

endmodule
